pipe_stage_reg: RTL

- Parametrised successor to the fixed-field Y86 stage registers (F/D, D/E, E/M, M/W). Carries one opaque payload plus a status field between two pipeline stages.
- Keeps the legacy stall/bubble controls and adds:
  - valid/ready handshake;
  - 2-entry skid buffer, so upstream ready is registered;
  - configurable bubble pattern;
  - saturating stall and bubble event counters for hazard-unit profiling.
- Instantiated once per stage boundary in the pipelined core.

---
 rtl/pipe_stage_reg_if.sv | 37 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle for one pipeline stage boundary.
// The slave modport is the stage register; the master modport drives it.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 272,
    parameter int unsigned STAT_W = 3
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic [STAT_W-1:0] in_stat_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic [STAT_W-1:0] out_stat_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_data_i,
        input  in_stat_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output out_stat_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_data_i,
        output in_stat_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  out_stat_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// legacy stall/bubble controls and saturating hazard event counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W       = 272,
    parameter int unsigned       STAT_W       = 3,
    parameter logic [DATA_W-1:0] BUBBLE_DATA  = '0,
    parameter logic [STAT_W-1:0] BUBBLE_STAT  = '0,
    parameter bit                BUBBLE_VALID = 1'b1,
    parameter int unsigned       CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    pipe_stage_reg_if.slave  bus,
    input  logic             stall_i,
    input  logic             bubble_i,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic [STAT_W-1:0] out_stat;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_data;
    logic [STAT_W-1:0] skid_stat;

    logic in_fire;
    logic out_fire;
    logic out_free;

    // Upstream ready depends only on registered skid state plus hazard controls.
    assign bus.in_ready_o  = ~skid_vld & ~stall_i & ~bubble_i;
    assign bus.out_valid_o = out_vld & ~stall_i;
    assign bus.out_data_o  = out_data;
    assign bus.out_stat_o  = out_stat;

    assign in_fire  = bus.in_valid_i & bus.in_ready_o;
    assign out_fire = bus.out_valid_o & bus.out_ready_i;
    assign out_free = ~out_vld | out_fire;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_stat  <= BUBBLE_STAT;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            skid_stat <= '0;
        end else if (bubble_i) begin
            out_vld  <= BUBBLE_VALID;
            out_data <= BUBBLE_DATA;
            out_stat <= BUBBLE_STAT;
            skid_vld <= 1'b0;
        end else if (!stall_i) begin
            if (out_free) begin
                if (skid_vld) begin
                    // Skid drains first to keep out-before-skid ordering.
                    out_vld  <= 1'b1;
                    out_data <= skid_data;
                    out_stat <= skid_stat;
                    if (in_fire) begin
                        skid_data <= bus.in_data_i;
                        skid_stat <= bus.in_stat_i;
                    end else begin
                        skid_vld <= 1'b0;
                    end
                end else if (in_fire) begin
                    out_vld  <= 1'b1;
                    out_data <= bus.in_data_i;
                    out_stat <= bus.in_stat_i;
                end else begin
                    out_vld <= 1'b0;
                end
            end else if (in_fire) begin
                skid_vld  <= 1'b1;
                skid_data <= bus.in_data_i;
                skid_stat <= bus.in_stat_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (cnt_clr_i) begin
                stall_cnt_o <= '0;
            end else if (stall_i && !bubble_i && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (cnt_clr_i) begin
                bubble_cnt_o <= '0;
            end else if (bubble_i && (bubble_cnt_o != '1)) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
        end
    end

endmodule
